// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : main control FSM for the multi-cycle MIPS datapath
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtSel,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] c_OP_R    = 6'b000000;
  localparam logic [5:0] c_OP_LW   = 6'b100011;
  localparam logic [5:0] c_OP_SW   = 6'b101011;
  localparam logic [5:0] c_OP_BEQ  = 6'b000100;
  localparam logic [5:0] c_OP_J    = 6'b000010;
  localparam logic [5:0] c_OP_ADDI = 6'b001000;
  localparam logic [5:0] c_OP_ANDI = 6'b001100;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_REX    = 4'd6,
    ST_RWB    = 4'd7,
    ST_BEQ    = 4'd8,
    ST_JMP    = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ANDIEX = 4'd11,
    ST_IMMWB  = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

  always_comb begin
    w_next      = ST_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ExtSel      = 1'b0;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;

    case (r_state)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        w_next  = mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB = 2'b11;
        case (op)
          c_OP_LW, c_OP_SW: w_next = ST_MEMADR;
          c_OP_R:           w_next = ST_REX;
          c_OP_BEQ:         w_next = ST_BEQ;
          c_OP_J:           w_next = ST_JMP;
          c_OP_ADDI:        w_next = ST_ADDIEX;
          c_OP_ANDI:        w_next = ST_ANDIEX;
          default: begin
            w_next     = ST_FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (op == c_OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = mem_ready ? ST_MEMWB : ST_MEMRD;
      end
      ST_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        w_next     = mem_ready ? ST_FETCH : ST_MEMWR;
      end
      ST_REX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = ST_RWB;
      end
      ST_RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      ST_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      ST_JMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      ST_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = ST_IMMWB;
      end
      ST_ANDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtSel  = 1'b1;
        ALUOp   = 2'b11;
        w_next  = ST_IMMWB;
      end
      ST_IMMWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: w_next = ST_FETCH;
    endcase

    // Strobes are suppressed while reset is held; selects keep FETCH values.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control : directed self-checking bench for multicycle_control
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ExtSel;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int n_tests;
  int n_fail;

  multicycle_control u_dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ExtSel     (ExtSel),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outputs for a given state, written from the control table.
  task automatic check_state(input logic [3:0] es, input logic rdy, input logic ill, input logic last);
    check("state", {28'd0, state}, {28'd0, es});
    check("RegWrite", {31'd0, RegWrite}, {31'd0, (es == 4 || es == 7 || es == 12)});
    check("MemWrite", {31'd0, MemWrite}, {31'd0, (es == 5)});
    check("instr_done", {31'd0, instr_done}, {31'd0, last && (es != 5 || rdy)});
    case (es)
      4'd0: begin
        check("F.MemRead", {31'd0, MemRead}, 32'd1);
        check("F.IRWrite", {31'd0, IRWrite}, {31'd0, rdy});
        check("F.PCWrite", {31'd0, PCWrite}, {31'd0, rdy});
        check("F.ALUSrcB", {30'd0, ALUSrcB}, 32'd1);
        check("F.IorD", {31'd0, IorD}, 32'd0);
      end
      4'd1: begin
        check("D.ALUSrcB", {30'd0, ALUSrcB}, 32'd3);
        check("D.illegal", {31'd0, illegal_op}, {31'd0, ill});
      end
      4'd2: begin
        check("MA.ALUSrcA", {31'd0, ALUSrcA}, 32'd1);
        check("MA.ALUSrcB", {30'd0, ALUSrcB}, 32'd2);
      end
      4'd3: begin
        check("MR.MemRead", {31'd0, MemRead}, 32'd1);
        check("MR.IorD", {31'd0, IorD}, 32'd1);
      end
      4'd4: check("MWB.MemtoReg", {31'd0, MemtoReg}, 32'd1);
      4'd5: check("MW.IorD", {31'd0, IorD}, 32'd1);
      4'd6: begin
        check("REX.ALUOp", {30'd0, ALUOp}, 32'd2);
        check("REX.ALUSrcB", {30'd0, ALUSrcB}, 32'd0);
      end
      4'd7: begin
        check("RWB.RegDst", {31'd0, RegDst}, 32'd1);
        check("RWB.MemtoReg", {31'd0, MemtoReg}, 32'd0);
      end
      4'd8: begin
        check("BEQ.PCWriteCond", {31'd0, PCWriteCond}, 32'd1);
        check("BEQ.PCSource", {30'd0, PCSource}, 32'd1);
        check("BEQ.ALUOp", {30'd0, ALUOp}, 32'd1);
      end
      4'd9: begin
        check("J.PCWrite", {31'd0, PCWrite}, 32'd1);
        check("J.PCSource", {30'd0, PCSource}, 32'd2);
      end
      4'd10: begin
        check("ADDI.ALUOp", {30'd0, ALUOp}, 32'd0);
        check("ADDI.ExtSel", {31'd0, ExtSel}, 32'd0);
        check("ADDI.ALUSrcB", {30'd0, ALUSrcB}, 32'd2);
      end
      4'd11: begin
        check("ANDI.ALUOp", {30'd0, ALUOp}, 32'd3);
        check("ANDI.ExtSel", {31'd0, ExtSel}, 32'd1);
        check("ANDI.ALUSrcB", {30'd0, ALUSrcB}, 32'd2);
      end
      4'd12: check("IMMWB.RegDst", {31'd0, RegDst}, 32'd0);
      default: check("state.range", {28'd0, es}, 32'd0);
    endcase
  endtask

  // Runs one instruction starting at a negedge in FETCH. seq holds the
  // expected state of each cycle, first cycle in the low nibble.
  task automatic run_instr(input string name, input logic [5:0] opc, input int n,
                           input logic [31:0] seq, input int stall_st, input int stalls,
                           input logic ill);
    logic [3:0] es;
    $display("[TB] running %s", name);
    op = opc;
    for (int i = 0; i < n; i++) begin
      es = seq[4*i +: 4];
      if (int'(es) == stall_st) begin
        for (int s = 0; s < stalls; s++) begin
          mem_ready = 1'b0;
          #1;
          check_state(es, 1'b0, ill, (i == n - 1));
          cyc();
        end
      end
      mem_ready = 1'b1;
      #1;
      check_state(es, 1'b1, ill, (i == n - 1));
      cyc();
    end
    #1;
    check({name, ".end_state"}, {28'd0, state}, 32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    op        = 6'b100011;
    mem_ready = 1'b1;
    #2;
    check("rst.state", {28'd0, state}, 32'd0);
    check("rst.MemRead", {31'd0, MemRead}, 32'd0);
    check("rst.IRWrite", {31'd0, IRWrite}, 32'd0);
    check("rst.PCWrite", {31'd0, PCWrite}, 32'd0);
    check("rst.instr_done", {31'd0, instr_done}, 32'd0);
    check("rst.ALUSrcB", {30'd0, ALUSrcB}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    run_instr("lw",      6'b100011, 5, 32'h0004_3210, -1, 0, 1'b0);
    run_instr("R",       6'b000000, 4, 32'h0000_7610, -1, 0, 1'b0);
    run_instr("addi",    6'b001000, 4, 32'h0000_CA10, -1, 0, 1'b0);
    run_instr("andi",    6'b001100, 4, 32'h0000_CB10, -1, 0, 1'b0);
    run_instr("sw_stall",6'b101011, 4, 32'h0000_5210,  5, 3, 1'b0);
    run_instr("beq",     6'b000100, 3, 32'h0000_0810, -1, 0, 1'b0);
    run_instr("j",       6'b000010, 3, 32'h0000_0910, -1, 0, 1'b0);
    run_instr("illegal", 6'b111111, 2, 32'h0000_0010, -1, 0, 1'b1);
    run_instr("lw_fstall",6'b100011,5, 32'h0004_3210,  0, 2, 1'b0);
    run_instr("lw_mstall",6'b100011,5, 32'h0004_3210,  3, 1, 1'b0);

    // Abandon a load in MEMRD with an asynchronous reset.
    op = 6'b100011;
    mem_ready = 1'b1;
    cyc();
    cyc();
    #1;
    check("abort.pre_state", {28'd0, state}, 32'd2);
    cyc();
    #1;
    check("abort.in_memrd", {28'd0, state}, 32'd3);
    reset = 1'b1;
    #1;
    check("abort.state", {28'd0, state}, 32'd0);
    check("abort.RegWrite", {31'd0, RegWrite}, 32'd0);
    check("abort.MemRead", {31'd0, MemRead}, 32'd0);
    cyc();
    #1;
    check("abort.held_state", {28'd0, state}, 32'd0);
    check("abort.held_RegWrite", {31'd0, RegWrite}, 32'd0);
    reset = 1'b0;
    run_instr("j_after_rst", 6'b000010, 3, 32'h0000_0910, -1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
